time_param_timer: RTL and testbench

TIME_PARAM_TIMER -- requirements
Module: time_param_timer

---
 rtl/time_param_pkg.sv | 17 +
 rtl/time_param_timer_if.sv | 26 ++
 rtl/countdown_timer.sv | 48 ++++
 rtl/time_param_timer.sv | 63 ++++++
 tb/tb_time_param_timer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/time_param_pkg.sv
// Shared types and default sizing for the programmable interval timer.
package time_param_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_WIDTH         = 4;
    localparam int DEF_NUM_INTERVALS = 4;

    // Select width; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/time_param_timer_if.sv
// Programming, start/tick and status signals of the interval timer.
interface time_param_timer_if #(
    parameter int WIDTH = 4,
    parameter int SW    = 2
);
    logic             prog_sync;
    logic [SW-1:0]    selector;
    logic [WIDTH-1:0] time_value;
    logic [SW-1:0]    interval;
    logic             start;
    logic             tick;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] remaining;
    logic             busy;
    logic             expired;

    modport master (
        output prog_sync, selector, time_value, interval, start, tick,
        input  value, remaining, busy, expired
    );

    modport slave (
        input  prog_sync, selector, time_value, interval, start, tick,
        output value, remaining, busy, expired
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter advanced by a time-base enable; pulses expired at zero.
module countdown_timer
    import time_param_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             tick,
    output logic [WIDTH-1:0] remaining,
    output logic             busy,
    output logic             expired
);

    state_t           state_reg;
    logic [WIDTH-1:0] remaining_reg;
    logic             expired_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            expired_reg   <= 1'b0;
        end else begin
            expired_reg <= 1'b0;
            // A load outranks a simultaneous tick, and restarts without a pulse.
            if (load) begin
                state_reg     <= RUN;
                remaining_reg <= load_value;
            end else if (state_reg == RUN && tick) begin
                if (remaining_reg <= WIDTH'(1)) begin
                    state_reg     <= IDLE;
                    remaining_reg <= '0;
                    expired_reg   <= 1'b1;
                end else begin
                    remaining_reg <= remaining_reg - WIDTH'(1);
                end
            end
        end
    end

    assign remaining = remaining_reg;
    assign busy      = (state_reg == RUN);
    assign expired   = expired_reg;

endmodule

// File: rtl/time_param_timer.sv
// Bank of programmable interval registers feeding a single countdown timer.
module time_param_timer
    import time_param_pkg::*;
#(
    parameter int                             NUM_INTERVALS = DEF_NUM_INTERVALS,
    parameter int                             WIDTH         = DEF_WIDTH,
    parameter logic [NUM_INTERVALS*WIDTH-1:0] DEFAULTS      = 16'h2936
) (
    input  logic             clk,
    input  logic             reset,
    time_param_timer_if.slave bus
);

    localparam int SW = sel_width(NUM_INTERVALS);
    localparam logic [SW:0] NUM_L = (SW + 1)'(NUM_INTERVALS);

    logic [WIDTH-1:0] bank [NUM_INTERVALS];
    logic             interval_ok;
    logic [WIDTH-1:0] value_next;

    generate
        for (genvar gi = 0; gi < NUM_INTERVALS; gi++) begin : g_slot
            logic [WIDTH-1:0] slot_reg;

            // Out-of-range selectors match no slot and are dropped.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    slot_reg <= DEFAULTS[gi*WIDTH +: WIDTH];
                end else if (bus.prog_sync && bus.selector == SW'(gi)) begin
                    slot_reg <= (bus.time_value == '0) ? WIDTH'(1) : bus.time_value;
                end
            end

            assign bank[gi] = slot_reg;
        end
    endgenerate

    assign interval_ok = ({1'b0, bus.interval} < NUM_L);

    always_comb begin
        value_next = '0;
        if (interval_ok) begin
            value_next = bank[bus.interval];
        end
    end

    assign bus.value = value_next;

    // Loading from the registered bank gives the pre-write value on a same-cycle write.
    countdown_timer #(
        .WIDTH(WIDTH)
    ) u_countdown (
        .clk       (clk),
        .reset     (reset),
        .load      (bus.start && interval_ok),
        .load_value(value_next),
        .tick      (bus.tick),
        .remaining (bus.remaining),
        .busy      (bus.busy),
        .expired   (bus.expired)
    );

endmodule

// File: tb/tb_time_param_timer.sv
// Directed vector bench for time_param_timer with the default 4 x 4-bit configuration.
module tb_time_param_timer;

    logic clk;
    logic reset;

    time_param_timer_if #(.WIDTH(4), .SW(2)) bus ();

    time_param_timer #(
        .NUM_INTERVALS(4),
        .WIDTH        (4),
        .DEFAULTS     (16'h2936)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ps;
        logic [1:0] sel;
        logic [3:0] tv;
        logic [1:0] itv;
        logic       st;
        logic       tk;
        logic [3:0] ev;   // value before the edge
        logic [3:0] er;   // remaining after the edge
        logic       eb;
        logic       ee;
    } vec_t;

    vec_t vecs[40];
    int   n_vec;
    int   n_applied;
    int   n_miss;

    function automatic vec_t mk(input logic ps, input logic [1:0] sel, input logic [3:0] tv,
                                input logic [1:0] itv, input logic st, input logic tk,
                                input logic [3:0] ev, input logic [3:0] er,
                                input logic eb, input logic ee);
        vec_t v;
        v.ps = ps; v.sel = sel; v.tv = tv; v.itv = itv; v.st = st; v.tk = tk;
        v.ev = ev; v.er = er; v.eb = eb; v.ee = ee;
        return v;
    endfunction

    task automatic drive_idle();
        bus.prog_sync  = 1'b0;
        bus.selector   = 2'd0;
        bus.time_value = 4'd0;
        bus.interval   = 2'd0;
        bus.start      = 1'b0;
        bus.tick       = 1'b0;
    endtask

    task automatic apply(input int idx);
        vec_t       v;
        logic [3:0] val_cap;
        v = vecs[idx];
        @(negedge clk);
        bus.prog_sync  = v.ps;
        bus.selector   = v.sel;
        bus.time_value = v.tv;
        bus.interval   = v.itv;
        bus.start      = v.st;
        bus.tick       = v.tk;
        #1;
        val_cap = bus.value;
        @(posedge clk);
        #1;
        n_applied++;
        if ({val_cap, bus.remaining, bus.busy, bus.expired} !== {v.ev, v.er, v.eb, v.ee}) begin
            n_miss++;
            $display("FAIL vec%0d: got value=%0d rem=%0d busy=%0b exp=%0b, want value=%0d rem=%0d busy=%0b exp=%0b",
                     idx, val_cap, bus.remaining, bus.busy, bus.expired, v.ev, v.er, v.eb, v.ee);
        end else begin
            $display("vec%0d ok: value=%0d rem=%0d busy=%0b exp=%0b",
                     idx, val_cap, bus.remaining, bus.busy, bus.expired);
        end
    endtask

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        n_applied++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end else begin
            $display("%s ok: %0d", name, got);
        end
    endtask

    initial begin
        int split;
        n_vec = 0; n_applied = 0; n_miss = 0;

        //                 ps  sel   tv    itv   st  tk  ev     er     eb  ee
        // default sweep
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd0, 0, 0, 4'd6,  4'd0,  0, 0);
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd1, 0, 0, 4'd3,  4'd0,  0, 0);
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd2, 0, 0, 4'd9,  4'd0,  0, 0);
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd3, 0, 0, 4'd2,  4'd0,  0, 0);
        // writes, zero clamp
        vecs[n_vec++] = mk(1, 2'd1, 4'd15, 2'd1, 0, 0, 4'd3,  4'd0,  0, 0);
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd1, 0, 0, 4'd15, 4'd0,  0, 0);
        vecs[n_vec++] = mk(1, 2'd1, 4'd0,  2'd1, 0, 0, 4'd15, 4'd0,  0, 0);
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd1, 0, 0, 4'd1,  4'd0,  0, 0);
        // tick in idle is ignored; countdown of interval 3
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd3, 0, 1, 4'd2,  4'd0,  0, 0);
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd3, 1, 0, 4'd2,  4'd2,  1, 0);
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd3, 0, 1, 4'd2,  4'd1,  1, 0);
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd3, 0, 1, 4'd2,  4'd0,  0, 1);
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd3, 0, 0, 4'd2,  4'd0,  0, 0);
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd3, 0, 1, 4'd2,  4'd0,  0, 0);
        // restart with simultaneous tick
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd0, 1, 0, 4'd6,  4'd6,  1, 0);
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd0, 0, 1, 4'd6,  4'd5,  1, 0);
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd0, 0, 1, 4'd6,  4'd4,  1, 0);
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd3, 1, 1, 4'd2,  4'd2,  1, 0);
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd3, 0, 0, 4'd2,  4'd2,  1, 0);
        // same-cycle write and start, write during run
        vecs[n_vec++] = mk(1, 2'd2, 4'd4,  2'd2, 1, 0, 4'd9,  4'd9,  1, 0);
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd2, 0, 0, 4'd4,  4'd9,  1, 0);
        vecs[n_vec++] = mk(1, 2'd0, 4'd7,  2'd2, 0, 1, 4'd4,  4'd8,  1, 0);
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd2, 1, 0, 4'd4,  4'd4,  1, 0);
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd0, 0, 0, 4'd7,  4'd4,  1, 0);
        // set up remaining=5 for the reset abort
        vecs[n_vec++] = mk(1, 2'd3, 4'd5,  2'd3, 0, 0, 4'd2,  4'd4,  1, 0);
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd3, 1, 0, 4'd5,  4'd5,  1, 0);
        split = n_vec;
        // after the abort: defaults back, first start honoured
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd1, 1, 0, 4'd3,  4'd3,  1, 0);
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd0, 0, 0, 4'd6,  4'd3,  1, 0);
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd2, 0, 0, 4'd9,  4'd3,  1, 0);
        vecs[n_vec++] = mk(0, 2'd0, 4'd0,  2'd3, 0, 1, 4'd2,  4'd2,  1, 0);

        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < split; i++) apply(i);

        // Asynchronous reset mid-count: outputs clear before any clock edge.
        @(negedge clk);
        drive_idle();
        bus.interval = 2'd3;
        bus.tick     = 1'b1;
        reset        = 1'b1;
        #1;
        check("async_rem",   bus.remaining, 4'd0);
        check("async_busy",  {3'd0, bus.busy}, 4'd0);
        check("async_exp",   {3'd0, bus.expired}, 4'd0);
        check("async_value", bus.value, 4'd2);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_hold%0d_exp", c), {3'd0, bus.expired}, 4'd0);
        end
        @(negedge clk);
        bus.tick = 1'b0;
        reset    = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_exp", {3'd0, bus.expired}, 4'd0);

        for (int i = split; i < n_vec; i++) apply(i);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
